// File: rtl/bam_fader_if.sv
// Ramp request channel into bam_fader: valid/ready handshake carrying the
// target duty cycle, step size and step interval.
interface bam_fader_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
);
    logic             target_valid;
    logic             target_ready;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] step;
    logic [CNT_W-1:0] interval;

    modport master (
        output target_valid, target, step, interval,
        input  target_ready
    );

    modport slave (
        input  target_valid, target, step, interval,
        output target_ready
    );
endinterface

// File: rtl/bam_fader.sv
// Duty-cycle ramp generator feeding the BAM stage. Walks o_duty_cycle from its
// present value to a requested target in fixed steps, one step every
// interval+1 cycles, and pulses o_done when the target is reached.
module bam_fader #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_on,
    bam_fader_if.slave       req,
    output logic [WIDTH-1:0] o_duty_cycle,
    output logic             o_busy,
    output logic             o_done
);
    typedef enum logic {IDLE, RAMP} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] target;
        logic [WIDTH-1:0] step;
        logic [CNT_W-1:0] interval;
    } ramp_cfg_t;

    state_t           state_q, state_d;
    ramp_cfg_t        cfg_q, cfg_d;
    logic [WIDTH-1:0] duty_q, duty_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;

    logic             accept;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] stepped;

    // Ready is purely combinational so software sees it drop with i_on/reset.
    assign req.target_ready = i_on & i_rst_n;
    assign accept           = req.target_valid & req.target_ready;

    // Candidate next duty value, clamped at the target in either direction.
    // The extra bit keeps the sum from wrapping and flags a negative difference.
    always_comb begin
        sum     = {1'b0, duty_q} + {1'b0, cfg_q.step};
        diff    = {1'b0, duty_q} - {1'b0, cfg_q.step};
        stepped = cfg_q.target;
        if (cfg_q.target > duty_q) begin
            if (sum < {1'b0, cfg_q.target})
                stepped = sum[WIDTH-1:0];
        end else begin
            if (!diff[WIDTH] && (diff[WIDTH-1:0] > cfg_q.target))
                stepped = diff[WIDTH-1:0];
        end
    end

    // Next-state logic: disable > accept > interval countdown / step.
    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        duty_d  = duty_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        if (!i_on) begin
            state_d = IDLE;
            duty_d  = '0;
            cnt_d   = '0;
        end else if (accept) begin
            // A new request replaces any ramp in flight; a step due this
            // cycle is dropped and the countdown restarts.
            cfg_d.target   = req.target;
            cfg_d.step     = (req.step == '0) ? WIDTH'(1) : req.step;
            cfg_d.interval = req.interval;
            cnt_d          = req.interval;
            if (req.target == duty_q) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end else begin
                state_d = RAMP;
            end
        end else if (state_q == RAMP) begin
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end else begin
                duty_d = stepped;
                cnt_d  = cfg_q.interval;
                if (stepped == cfg_q.target) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cfg_q   <= '0;
            duty_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            duty_q  <= duty_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    assign o_duty_cycle = duty_q;
    assign o_busy       = (state_q == RAMP);
    assign o_done       = done_q;
endmodule

// File: tb/tb_bam_fader.sv
// Directed bench for bam_fader: reset, up/down ramps with clamping, saturation,
// zero step, retarget, zero-distance request, step cancel and disable.
module tb_bam_fader;
    logic i_clk = 1'b0;
    logic i_rst_n;
    logic i_on;
    logic [15:0] o_duty_cycle;
    logic        o_busy;
    logic        o_done;

    int n_cmp = 0;
    int n_err = 0;

    bam_fader_if #(.WIDTH(16), .CNT_W(16)) rif ();

    bam_fader #(.WIDTH(16), .CNT_W(16)) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_on         (i_on),
        .req          (rif),
        .o_duty_cycle (o_duty_cycle),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, req);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1ns later.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // Present one request for exactly one edge.
    task automatic send(input logic [15:0] tgt, input logic [15:0] stp, input logic [15:0] ivl);
        rif.target_valid = 1'b1;
        rif.target       = tgt;
        rif.step         = stp;
        rif.interval     = ivl;
        tick();
        rif.target_valid = 1'b0;
    endtask

    task automatic clear_duty();
        i_on = 1'b0;
        tick();
        chk("clear_duty", o_duty_cycle, 16'd0);
        i_on = 1'b1;
    endtask

    initial begin
        i_rst_n          = 1'b0;
        i_on             = 1'b1;
        rif.target_valid = 1'b1;
        rif.target       = 16'd50;
        rif.step         = 16'd1;
        rif.interval     = 16'd0;

        // Reset held with a pending request: nothing may be accepted.
        repeat (3) begin
            tick();
            chk("rst_ready", rif.target_ready, 1'b0);
            chk("rst_duty", o_duty_cycle, 16'd0);
            chk("rst_busy", o_busy, 1'b0);
            chk("rst_done", o_done, 1'b0);
        end
        rif.target_valid = 1'b0;
        i_rst_n = 1'b1;
        #1;
        chk("rel_ready", rif.target_ready, 1'b1);
        tick();

        // Up-ramp 0 -> 100, step 25, interval 3.
        send(16'd100, 16'd25, 16'd3);
        for (int i = 1; i <= 16; i++) begin
            chk("up_busy", o_busy, 1'b1);
            tick();
            chk("up_duty", o_duty_cycle, 32'(25 * (i / 4)));
            chk("up_done", o_done, (i == 16) ? 1'b1 : 1'b0);
        end
        chk("up_busy_end", o_busy, 1'b0);
        tick();
        chk("up_done_clr", o_done, 1'b0);

        // Down-ramp with overshoot clamp: 100 -> 10, step 40, interval 0.
        send(16'd10, 16'd40, 16'd0);
        chk("dn_busy", o_busy, 1'b1);
        tick(); chk("dn_d1", o_duty_cycle, 16'd60); chk("dn_n1", o_done, 1'b0);
        tick(); chk("dn_d2", o_duty_cycle, 16'd20); chk("dn_n2", o_done, 1'b0);
        tick(); chk("dn_d3", o_duty_cycle, 16'd10); chk("dn_n3", o_done, 1'b1);
        chk("dn_busy_end", o_busy, 1'b0);

        // Saturation at full scale.
        clear_duty();
        send(16'hFFFF, 16'h8000, 16'd0);
        tick(); chk("sat_d1", o_duty_cycle, 16'h8000); chk("sat_n1", o_done, 1'b0);
        tick(); chk("sat_d2", o_duty_cycle, 16'hFFFF); chk("sat_n2", o_done, 1'b1);

        // Down by a step larger than the value: clamps at target, no wrap.
        send(16'd5, 16'hFFFF, 16'd0);
        tick(); chk("flr_d", o_duty_cycle, 16'd5); chk("flr_n", o_done, 1'b1);

        // Step of zero behaves as one.
        send(16'd7, 16'd0, 16'd0);
        tick(); chk("s0_d1", o_duty_cycle, 16'd6); chk("s0_n1", o_done, 1'b0);
        tick(); chk("s0_d2", o_duty_cycle, 16'd7); chk("s0_n2", o_done, 1'b1);

        // Retarget mid-ramp: 0 -> 200 step 10 interval 1, redirect to 30 at 60.
        clear_duty();
        send(16'd200, 16'd10, 16'd1);
        for (int j = 1; j <= 12; j++) begin
            tick();
            chk("rt_up", o_duty_cycle, 32'(10 * (j / 2)));
            chk("rt_up_done", o_done, 1'b0);
        end
        send(16'd30, 16'd10, 16'd1);
        chk("rt_hold", o_duty_cycle, 16'd60);
        chk("rt_busy", o_busy, 1'b1);
        for (int j = 1; j <= 6; j++) begin
            tick();
            chk("rt_dn", o_duty_cycle, 32'(60 - 10 * (j / 2)));
            chk("rt_done", o_done, (j == 6) ? 1'b1 : 1'b0);
        end
        tick();
        chk("rt_done_clr", o_done, 1'b0);

        // Zero-distance request: done pulse only, never busy.
        send(16'd30, 16'd1, 16'd0);
        chk("zd_done", o_done, 1'b1);
        chk("zd_busy", o_busy, 1'b0);
        tick();
        chk("zd_done_clr", o_done, 1'b0);
        chk("zd_busy2", o_busy, 1'b0);
        chk("zd_duty", o_duty_cycle, 16'd30);

        // Accept coinciding with a due step cancels that step.
        send(16'd100, 16'd5, 16'd0);
        chk("cx_d0", o_duty_cycle, 16'd30);
        tick(); chk("cx_d1", o_duty_cycle, 16'd35);
        send(16'd100, 16'd5, 16'd2);
        chk("cx_cancel", o_duty_cycle, 16'd35);
        tick(); chk("cx_w1", o_duty_cycle, 16'd35);
        tick(); chk("cx_w2", o_duty_cycle, 16'd35);
        tick(); chk("cx_step", o_duty_cycle, 16'd40);

        // Disable mid-ramp: immediate clear, no done pulse.
        i_on = 1'b0;
        #1;
        chk("off_ready", rif.target_ready, 1'b0);
        tick();
        chk("off_duty", o_duty_cycle, 16'd0);
        chk("off_busy", o_busy, 1'b0);
        chk("off_done", o_done, 1'b0);
        i_on = 1'b1;
        #1;
        chk("on_ready", rif.target_ready, 1'b1);
        tick();
        chk("on_duty", o_duty_cycle, 16'd0);
        chk("on_busy", o_busy, 1'b0);
        chk("on_done", o_done, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
